// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : N-channel arbiter sharing one LC-3b memory port. Round-robin by
//            default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MASK_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          cli_read,
    input  logic [NUM_PORTS-1:0]          cli_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   cli_address,
    input  logic [NUM_PORTS*DATA_W-1:0]   cli_wdata,
    input  logic [NUM_PORTS*MASK_W-1:0]   cli_byte_enable,
    output logic [NUM_PORTS-1:0]          cli_resp,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [MASK_W-1:0]             mem_byte_enable,
    input  logic                          mem_resp,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]           r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_grant_id;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [MASK_W-1:0]    r_mask;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [NUM_PORTS-1:0] w_resp;

    assign w_req = cli_read | cli_write;
    assign w_any = |w_req;

    // Search from r_rr_ptr upward; in fixed-priority builds r_rr_ptr stays 0,
    // which turns the same search into lowest-index-wins.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        w_sel = r_rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_PORTS;
            if (!found && w_req[idx]) begin
                found = 1'b1;
                w_sel = PTR_W'(idx);
            end
        end
    end

    assign w_next_ptr = (r_grant_id == PTR_W'(NUM_PORTS - 1)) ? '0 : r_grant_id + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state     <= c_BUSY;
                        r_grant_id  <= w_sel;
                        // Write wins when a channel raises both strobes.
                        r_mem_write <= cli_write[w_sel];
                        r_mem_read  <= cli_read[w_sel] & ~cli_write[w_sel];
                        r_addr      <= cli_address[int'(w_sel)*ADDR_W +: ADDR_W];
                        r_wdata     <= cli_wdata[int'(w_sel)*DATA_W +: DATA_W];
                        r_mask      <= cli_byte_enable[int'(w_sel)*MASK_W +: MASK_W];
                    end
                end
                c_BUSY: begin
                    if (mem_resp) begin
                        r_state     <= c_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        r_rr_ptr    <= w_next_ptr;
`endif
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_next_ptr;
`endif

    always_comb begin
        w_resp = '0;
        if (r_state == c_BUSY && mem_resp) begin
            w_resp[r_grant_id] = 1'b1;
        end
    end

    assign cli_resp        = w_resp;
    assign cli_rdata       = mem_rdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_mask;
    assign grant_id        = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter (2 channels, 16-bit words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit c_FIXED = 1'b1;
`else
    localparam bit c_FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cli_read;
    logic [1:0]  cli_write;
    logic [31:0] cli_address;
    logic [31:0] cli_wdata;
    logic [3:0]  cli_byte_enable;
    logic [1:0]  cli_resp;
    logic [15:0] cli_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic [0:0]  grant_id;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cli_read(cli_read), .cli_write(cli_write), .cli_address(cli_address),
        .cli_wdata(cli_wdata), .cli_byte_enable(cli_byte_enable),
        .cli_resp(cli_resp), .cli_rdata(cli_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant_id(grant_id)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [15:0] a0, a1, d0, d1;
        logic [1:0]  m0, m1;
        int          dly;
        logic [15:0] rdata;
        int          eg;
        logic        erd, ewr;
        logic [15:0] eaddr, ewd;
        logic [1:0]  emask;
    } vec_t;

    vec_t vecs [6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Starts and ends with the DUT idle and no requests pending.
    task automatic do_vec(input vec_t v, input int i);
        @(posedge clk); #1;
        cli_read        = v.rd;
        cli_write       = v.wr;
        cli_address     = {v.a1, v.a0};
        cli_wdata       = {v.d1, v.d0};
        cli_byte_enable = {v.m1, v.m0};
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d mem_read", i),  32'(mem_read),  32'(v.erd));
        chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(v.ewr));
        chk($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(v.eaddr));
        chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(v.ewd));
        chk($sformatf("v%0d mem_byte_enable", i), 32'(mem_byte_enable), 32'(v.emask));
        chk($sformatf("v%0d grant_id", i),  32'(grant_id),  32'(v.eg));
        chk($sformatf("v%0d early cli_resp", i), 32'(cli_resp), 32'd0);
        for (int c = 1; c < v.dly; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold mem_read", i), 32'(mem_read), 32'(v.erd));
        end
        mem_resp  = 1'b1;
        mem_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d cli_resp", i),  32'(cli_resp),  32'(2'b01 << v.eg));
        chk($sformatf("v%0d cli_rdata", i), 32'(cli_rdata), 32'(v.rdata));
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        cli_read  = 2'b00;
        cli_write = 2'b00;
        @(negedge clk);
        chk($sformatf("v%0d turnaround", i), 32'({mem_read, mem_write}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rd:2'b10, wr:2'b00, a0:16'h0000, a1:16'h1234, d0:16'h0000, d1:16'h0000,
                    m0:2'b00, m1:2'b11, dly:3, rdata:16'hBEEF,
                    eg:1, erd:1'b1, ewr:1'b0, eaddr:16'h1234, ewd:16'h0000, emask:2'b11};
        vecs[1] = '{rd:2'b00, wr:2'b01, a0:16'h0040, a1:16'h0000, d0:16'hA5A5, d1:16'h0000,
                    m0:2'b01, m1:2'b00, dly:1, rdata:16'h0000,
                    eg:0, erd:1'b0, ewr:1'b1, eaddr:16'h0040, ewd:16'hA5A5, emask:2'b01};
        vecs[3] = '{rd:2'b11, wr:2'b00, a0:16'h1002, a1:16'h2002, d0:16'h3333, d1:16'h4444,
                    m0:2'b11, m1:2'b01, dly:1, rdata:16'h2468,
                    eg:0, erd:1'b1, ewr:1'b0, eaddr:16'h1002, ewd:16'h3333, emask:2'b11};
        vecs[4] = '{rd:2'b01, wr:2'b01, a0:16'h0050, a1:16'h0000, d0:16'hC3C3, d1:16'h0000,
                    m0:2'b11, m1:2'b00, dly:2, rdata:16'hDEAD,
                    eg:0, erd:1'b0, ewr:1'b1, eaddr:16'h0050, ewd:16'hC3C3, emask:2'b11};
        if (c_FIXED) begin
            vecs[2] = '{rd:2'b11, wr:2'b00, a0:16'h1000, a1:16'h2000, d0:16'h1111, d1:16'h2222,
                        m0:2'b10, m1:2'b11, dly:2, rdata:16'h1357,
                        eg:0, erd:1'b1, ewr:1'b0, eaddr:16'h1000, ewd:16'h1111, emask:2'b10};
            vecs[5] = '{rd:2'b01, wr:2'b10, a0:16'h0060, a1:16'h0070, d0:16'h7777, d1:16'h8888,
                        m0:2'b11, m1:2'b10, dly:1, rdata:16'h0F0F,
                        eg:0, erd:1'b1, ewr:1'b0, eaddr:16'h0060, ewd:16'h7777, emask:2'b11};
        end else begin
            vecs[2] = '{rd:2'b11, wr:2'b00, a0:16'h1000, a1:16'h2000, d0:16'h1111, d1:16'h2222,
                        m0:2'b10, m1:2'b11, dly:2, rdata:16'h1357,
                        eg:1, erd:1'b1, ewr:1'b0, eaddr:16'h2000, ewd:16'h2222, emask:2'b11};
            vecs[5] = '{rd:2'b01, wr:2'b10, a0:16'h0060, a1:16'h0070, d0:16'h7777, d1:16'h8888,
                        m0:2'b11, m1:2'b10, dly:1, rdata:16'h0F0F,
                        eg:1, erd:1'b0, ewr:1'b1, eaddr:16'h0070, ewd:16'h8888, emask:2'b10};
        end

        // Reset with both channels requesting.
        rst_n = 1'b0;
        cli_read = 2'b11; cli_write = 2'b00;
        cli_address = '0; cli_wdata = '0; cli_byte_enable = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        chk("reset cli_resp", 32'(cli_resp), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset mem_address", 32'(mem_address), 32'd0);
        cli_read = 2'b00;
        rst_n = 1'b1;

        // mem_resp while idle must not produce a response or start a transfer.
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        chk("idle mem_resp cli_resp", 32'(cli_resp), 32'd0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        chk("idle mem_resp no transfer", 32'({mem_read, mem_write}), 32'd0);

        for (int i = 0; i < 6; i++) do_vec(vecs[i], i);

        // Client drops its request mid-transfer; response still delivered.
        @(negedge clk);
        cli_read = 2'b01; cli_address = {16'h0000, 16'h3000};
        @(posedge clk); #1;
        cli_read = 2'b00;
        @(negedge clk);
        chk("drop mem_read", 32'(mem_read), 32'd1);
        chk("drop mem_address", 32'(mem_address), 32'h3000);
        @(negedge clk);
        chk("drop hold mem_read", 32'(mem_read), 32'd1);
        mem_resp = 1'b1; mem_rdata = 16'h5A5A;
        #1;
        chk("drop cli_resp", 32'(cli_resp), 32'b01);
        chk("drop cli_rdata", 32'(cli_rdata), 32'h5A5A);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        chk("drop turnaround", 32'({mem_read, mem_write}), 32'd0);

        // Continuous requests from a fresh reset: grant order and 1-cycle gaps.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        cli_read = 2'b11; cli_address = {16'h2100, 16'h1100};
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int eg;
            eg = c_FIXED ? 0 : (k % 2);
            @(negedge clk);
            chk($sformatf("rr%0d mem_read", k), 32'(mem_read), 32'd1);
            chk($sformatf("rr%0d grant_id", k), 32'(grant_id), 32'(eg));
            mem_resp = 1'b1; mem_rdata = 16'(16'h0100 + k);
            #1;
            chk($sformatf("rr%0d cli_resp", k), 32'(cli_resp), 32'(2'b01 << eg));
            @(posedge clk); #1;
            mem_resp = 1'b0;
            @(negedge clk);
            chk($sformatf("rr%0d gap", k), 32'({mem_read, mem_write}), 32'd0);
        end
        cli_read = 2'b00;
        @(negedge clk);
        chk("rr drained", 32'({mem_read, mem_write}), 32'd0);

        // Read+write conflict, then reset mid-transfer abandons it.
        cli_read = 2'b01; cli_write = 2'b01; cli_address = {16'h0000, 16'h0050};
        @(posedge clk);
        @(negedge clk);
        chk("abort mem_write", 32'(mem_write), 32'd1);
        chk("abort mem_read", 32'(mem_read), 32'd0);
        mem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort async mem_write", 32'(mem_write), 32'd0);
        chk("abort cli_resp", 32'(cli_resp), 32'd0);
        cli_read = 2'b00; cli_write = 2'b00; mem_resp = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort no replay %0d", c), 32'({mem_read, mem_write, cli_resp}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
